branch_unit: RTL and testbench
==============================

// Module: branch_unit
// PURPOSE
//   Branch-condition evaluator for the RV32I execute stage. It compares srcA and srcB
//   according to the branch code on aluControl and drives zero=1 when the branch is taken.
//   The decision is combinational, so the PC-select mux can use it in the same cycle.
//   A registered copy of the decision is kept for the pipeline and for debug/statistics.
// PARAMETERS
//   DATA_WIDTH  32  operand width in bits; legal range is >= 2
// PORTS
//   clk         in   1           system clock; registers update on the rising edge
//   rst_n       in   1           asynchronous, active-low reset
//   srcA        in   DATA_WIDTH  operand A (rs1)
//   srcB        in   DATA_WIDTH  operand B (rs2)
//   aluControl  in   4           operation code; bit3=1 selects a branch op
//   branch_i    in   1           qualifier: a branch instruction is in execute this cycle
//   zero        out  1           combinational branch-taken flag
//   taken_q     out  1           zero registered, captured when branch_i=1
//   valid_q     out  1           1 on the cycle after branch_i=1, otherwise 0
// BEHAVIOUR
//   - aluControl decode; zero is a pure function of srcA, srcB and aluControl:
//       4'b1000 BEQ  : zero = (srcA == srcB)
//       4'b1001 BNE  : zero = (srcA != srcB)
//       4'b1100 BLT  : zero = ($signed(srcA) <  $signed(srcB))
//       4'b1101 BGE  : zero = ($signed(srcA) >= $signed(srcB))
//       4'b1110 BLTU : zero = (srcA <  srcB), unsigned
//       4'b1111 BGEU : zero = (srcA >= srcB), unsigned
//       4'b1010, 4'b1011, and all codes with bit3=0: zero = 0 (not a branch)
//   - zero does not depend on branch_i, clk or rst_n. No latches; X-free for known inputs.
//   - Signed compare: DATA_WIDTH-bit two's complement. Required results:
//       - MSB-set operand is less than any non-negative operand.
//       - Most-negative value vs most-positive value gives BLT=1 and BLTU=0.
//   - Registers (rising clk):
//       - taken_q <= branch_i ? zero : taken_q
//       - valid_q <= branch_i
//   - Reset: rst_n low asynchronously forces taken_q=0 and valid_q=0, and all counters
//     to 0. The release edge is synchronous to clk. Reset asserted mid-operation discards
//     any pending capture. zero keeps tracking its inputs during reset.
//   - Latency: zero has 0 cycles; taken_q and valid_q have 1 cycle.
//   - Back-to-back branch_i: one capture per cycle, no bubbles required.
// CONFIGURATION
//   BRANCH_STATS_EN defined:
//     - Adds outputs br_count[31:0] and taken_count[31:0].
//     - br_count increments on every cycle with branch_i=1 and a branch-op code.
//     - taken_count increments when, additionally, zero=1.
//     - Both counters wrap from 32'hFFFF_FFFF to 0 and reset to 0.
//   BRANCH_STATS_EN undefined:
//     - The counter ports and their logic are absent.
//     - All other behaviour is identical.
// TESTING
//   1. BEQ, srcA=10, srcB=10, aluControl=1000 -> zero=1; srcB=5 -> zero=0.
//   2. BNE, srcA=10, srcB=5, aluControl=1001 -> zero=1; srcB=10 -> zero=0.
//   3. srcA=32'hFFFF_FFFF, srcB=1:
//        BLT -> 1, BGE -> 0, BLTU -> 0, BGEU -> 1.
//   4. aluControl=0000, 1010, or 1011 with srcA=srcB=7 -> zero=0.
//   5. rst_n low mid-run -> taken_q=0 and valid_q=0 immediately, without a clock edge.
//      After release, branch_i=1 with BEQ 3,3 -> next cycle taken_q=1 and valid_q=1.
//   6. With BRANCH_STATS_EN: 4 branches, 3 of them taken -> br_count=4, taken_count=3.
//      Then reset -> both counters 0.

Source files
------------

// File: rtl/branch_unit.sv
// Branch-condition evaluator for the RV32I execute stage: combinational taken flag plus a registered copy.
// Optional statistics counters are enabled with `define BRANCH_STATS_EN.
module branch_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] srcA,
  input  logic [DATA_WIDTH-1:0] srcB,
  input  logic [3:0]            aluControl,
  input  logic                  branch_i,
  output logic                  zero,
  output logic                  taken_q,
  output logic                  valid_q
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           br_count,
  output logic [31:0]           taken_count
`endif
);

  logic eq, lt_s, lt_u;
  logic is_br_op;
  logic taken_d, valid_d;

  assign eq   = (srcA == srcB);
  assign lt_s = ($signed(srcA) < $signed(srcB));
  assign lt_u = (srcA < srcB);

  // Branch decode; 1010/1011 and all bit3=0 codes are not branches
  always_comb begin
    zero     = 1'b0;
    is_br_op = 1'b0;
    case (aluControl)
      4'b1000: begin zero = eq;    is_br_op = 1'b1; end
      4'b1001: begin zero = ~eq;   is_br_op = 1'b1; end
      4'b1100: begin zero = lt_s;  is_br_op = 1'b1; end
      4'b1101: begin zero = ~lt_s; is_br_op = 1'b1; end
      4'b1110: begin zero = lt_u;  is_br_op = 1'b1; end
      4'b1111: begin zero = ~lt_u; is_br_op = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    taken_d = branch_i ? zero : taken_q;
    valid_d = branch_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      taken_q <= taken_d;
      valid_q <= valid_d;
    end
  end

`ifdef BRANCH_STATS_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

  // Counters wrap naturally at 2^32
  always_comb begin
    br_cnt_d = br_cnt_q + CNT_W'(branch_i & is_br_op);
    tk_cnt_d = tk_cnt_q + CNT_W'(branch_i & is_br_op & zero);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      tk_cnt_q <= tk_cnt_d;
    end
  end

  assign br_count    = br_cnt_q;
  assign taken_count = tk_cnt_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: directed cases plus random stimulus against a spec-level model.
module tb_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] srcA, srcB;
  logic [3:0]  aluControl;
  logic        branch_i;
  logic        zero, taken_q, valid_q;
`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, taken_count;
`endif

  int errors = 0;
  int checks = 0;

  logic        exp_taken, exp_valid;
  int unsigned exp_br, exp_tk;

  branch_unit #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .srcA       (srcA),
    .srcB       (srcB),
    .aluControl (aluControl),
    .branch_i   (branch_i),
    .zero       (zero),
    .taken_q    (taken_q),
    .valid_q    (valid_q)
`ifdef BRANCH_STATS_EN
    ,
    .br_count   (br_count),
    .taken_count(taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two's complement value of a 32-bit pattern, as a wide integer
  function automatic longint to_int(input logic [31:0] v);
    if (v[31]) return longint'(v) - 64'sd4294967296;
    return longint'(v);
  endfunction

  function automatic bit is_branch(input logic [3:0] ctl);
    return (ctl == 4'd8) || (ctl == 4'd9) || (ctl >= 4'd12);
  endfunction

  function automatic logic model_zero(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl);
    longint sa = to_int(a);
    longint sb = to_int(b);
    longint ua = longint'(a);
    longint ub = longint'(b);
    case (ctl)
      4'd8:  return ua == ub;
      4'd9:  return ua != ub;
      4'd12: return sa <  sb;
      4'd13: return sa >= sb;
      4'd14: return ua <  ub;
      4'd15: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_taken_q"}, 32'(taken_q), 32'(exp_taken));
    chk({tag, "_valid_q"}, 32'(valid_q), 32'(exp_valid));
`ifdef BRANCH_STATS_EN
    chk({tag, "_br_count"},    br_count,    exp_br);
    chk({tag, "_taken_count"}, taken_count, exp_tk);
`endif
  endtask

  // Drive one cycle of stimulus: check zero combinationally, then registered outputs after the edge
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [3:0] ctl,
                      input logic br, input string tag);
    logic ez;
    srcA = a; srcB = b; aluControl = ctl; branch_i = br;
    #1;
    ez = model_zero(a, b, ctl);
    chk({tag, "_zero"}, 32'(zero), 32'(ez));
    @(posedge clk);
    if (br) exp_taken = ez;
    exp_valid = br;
    if (br && is_branch(ctl)) begin
      exp_br++;
      if (ez) exp_tk++;
    end
    #1;
    chk_regs(tag);
  endtask

  task automatic model_reset();
    exp_taken = 1'b0;
    exp_valid = 1'b0;
    exp_br    = 0;
    exp_tk    = 0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic [3:0]  ctl;
    model_reset();
    rst_n = 1'b0; srcA = '0; srcB = '0; aluControl = '0; branch_i = 1'b0;
    #12;
    chk("reset_zero", 32'(zero), 32'(0));
    chk_regs("reset");
    rst_n = 1'b1;

    step(32'd10, 32'd10, 4'b1000, 1'b1, "beq_eq");
    step(32'd10, 32'd5,  4'b1000, 1'b1, "beq_ne");
    step(32'd10, 32'd5,  4'b1001, 1'b1, "bne_ne");
    step(32'd10, 32'd10, 4'b1001, 1'b1, "bne_eq");
    step(32'hFFFF_FFFF, 32'd1, 4'b1100, 1'b1, "blt_neg");
    step(32'hFFFF_FFFF, 32'd1, 4'b1101, 1'b1, "bge_neg");
    step(32'hFFFF_FFFF, 32'd1, 4'b1110, 1'b1, "bltu_big");
    step(32'hFFFF_FFFF, 32'd1, 4'b1111, 1'b1, "bgeu_big");
    step(32'h8000_0000, 32'h7FFF_FFFF, 4'b1100, 1'b1, "blt_minmax");
    step(32'h8000_0000, 32'h7FFF_FFFF, 4'b1110, 1'b1, "bltu_minmax");
    step(32'h8000_0000, 32'd0, 4'b1100, 1'b1, "blt_min_zero");
    step(32'd7, 32'd7, 4'b0000, 1'b1, "nonbr_0000");
    step(32'd7, 32'd7, 4'b1010, 1'b1, "nonbr_1010");
    step(32'd7, 32'd7, 4'b1011, 1'b1, "nonbr_1011");
    step(32'd3, 32'd3, 4'b1000, 1'b1, "beq_set");
    step(32'd3, 32'd4, 4'b1000, 1'b0, "hold_no_br");

    // Asynchronous reset mid-run with a capture pending
    step(32'd3, 32'd3, 4'b1000, 1'b1, "pre_rst");
    srcA = 32'd3; srcB = 32'd3; aluControl = 4'b1000; branch_i = 1'b1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_regs("async_rst");
    chk("rst_zero_tracks", 32'(zero), 32'(1));
    @(posedge clk); #1;
    chk_regs("rst_hold");
    rst_n = 1'b1;
    step(32'd3, 32'd3, 4'b1000, 1'b1, "post_rst");
    step(32'd3, 32'd9, 4'b1000, 1'b1, "b2b_nt");
    step(32'd9, 32'd3, 4'b1001, 1'b1, "b2b_t");

    for (int i = 0; i < 300; i++) begin
      a = $urandom();
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ 32'h8000_0000;
        2: b = a + 32'(1);
        default: b = $urandom();
      endcase
      ctl = 4'($urandom_range(0, 15));
      step(a, b, ctl, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Statistics: 4 branches, 3 taken, plus ignored non-branch and unqualified cycles
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_regs("stats_clr");
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(32'd1, 32'd1, 4'b1000, 1'b1, "st1");
    step(32'd1, 32'd2, 4'b1001, 1'b1, "st2");
    step(32'd7, 32'd7, 4'b1010, 1'b1, "st_nonbr");
    step(32'd5, 32'd5, 4'b1000, 1'b0, "st_nobr");
    step(32'd2, 32'd1, 4'b1110, 1'b1, "st3");
    step(32'd2, 32'd1, 4'b1111, 1'b1, "st4");
`ifdef BRANCH_STATS_EN
    chk("stats_br4", br_count, 32'd4);
    chk("stats_tk3", taken_count, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("stats_br_rst", br_count, 32'd0);
    chk("stats_tk_rst", taken_count, 32'd0);
    rst_n = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
